// File: rtl/ws2812b_frame_scheduler_if.sv
// Host write port and chain-driver pull port of the WS2812b frame scheduler.
interface ws2812b_frame_scheduler_if #(
    parameter int NUM_LEDS = 4,
    parameter int FCNT_W   = 16
);
    localparam int AW = $clog2(NUM_LEDS);

    logic              wr_valid;
    logic              wr_ready;
    logic [AW-1:0]     wr_addr;
    logic [23:0]       wr_rgb;
    logic              frame_commit;
    logic              commit_pending;
    logic [7:0]        brightness;
    logic              drv_data_request;
    logic [AW-1:0]     drv_address;
    logic [7:0]        drv_red;
    logic [7:0]        drv_green;
    logic [7:0]        drv_blue;
    logic              frame_start;
    logic [FCNT_W-1:0] frame_count;

    modport master (
        output wr_valid, wr_addr, wr_rgb, frame_commit, brightness,
               drv_data_request, drv_address,
        input  wr_ready, commit_pending, drv_red, drv_green, drv_blue,
               frame_start, frame_count
    );

    modport slave (
        input  wr_valid, wr_addr, wr_rgb, frame_commit, brightness,
               drv_data_request, drv_address,
        output wr_ready, commit_pending, drv_red, drv_green, drv_blue,
               frame_start, frame_count
    );
endinterface

// File: rtl/ws2812b_frame_scheduler.sv
// Double-buffered LED frame store; banks swap only on a driver address-0 pull so
// the chain never shows a torn frame. Returns brightness-scaled RGB one cycle after each pull.
module ws2812b_frame_scheduler #(
    parameter int NUM_LEDS = 4,
    parameter int FCNT_W   = 16
) (
    input logic                     clk,
    input logic                     reset,
    ws2812b_frame_scheduler_if.slave bus
);
    localparam int AW = $clog2(NUM_LEDS);

    logic              front_sel_q, front_sel_d;
    logic              blank_q, blank_d;
    logic              commit_pending_q, commit_pending_d;
    logic              frame_start_q, frame_start_d;
    logic [7:0]        bright_q, bright_d;
    logic [FCNT_W-1:0] frame_count_q, frame_count_d;
    logic [23:0]       drv_rgb_q, drv_rgb_d;

    logic [23:0]       mem_q [0:2*NUM_LEDS-1];

    logic              boundary;
    logic              swap;
    logic              wr_en;
    logic [23:0]       rd_word;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return 8'(p >> 8);
    endfunction

    always_comb begin
        boundary         = bus.drv_data_request && (bus.drv_address == '0);
        swap             = boundary && commit_pending_q;
        wr_en            = bus.wr_valid && !commit_pending_q;

        front_sel_d      = front_sel_q;
        blank_d          = blank_q;
        commit_pending_d = commit_pending_q;
        frame_count_d    = frame_count_q;
        bright_d         = bright_q;
        frame_start_d    = boundary;
        drv_rgb_d        = drv_rgb_q;

        if (bus.frame_commit && !commit_pending_q)
            commit_pending_d = 1'b1;

        // A commit in the boundary cycle only sets pending; the swap waits a whole frame.
        if (swap) begin
            front_sel_d      = ~front_sel_q;
            blank_d          = 1'b0;
            commit_pending_d = 1'b0;
            frame_count_d    = frame_count_q + 1'b1;
        end

        if (boundary)
            bright_d = bus.brightness;

        // Read uses post-swap bank and freshly latched brightness.
        rd_word = mem_q[{front_sel_d, bus.drv_address}];
        if (bus.drv_data_request) begin
            if (blank_d)
                drv_rgb_d = 24'd0;
            else
                drv_rgb_d = {scale(rd_word[23:16], bright_d),
                             scale(rd_word[15:8],  bright_d),
                             scale(rd_word[7:0],   bright_d)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            front_sel_q      <= 1'b0;
            blank_q          <= 1'b1;
            commit_pending_q <= 1'b0;
            frame_start_q    <= 1'b0;
            bright_q         <= 8'd255;
            frame_count_q    <= '0;
            drv_rgb_q        <= 24'd0;
        end else begin
            front_sel_q      <= front_sel_d;
            blank_q          <= blank_d;
            commit_pending_q <= commit_pending_d;
            frame_start_q    <= frame_start_d;
            bright_q         <= bright_d;
            frame_count_q    <= frame_count_d;
            drv_rgb_q        <= drv_rgb_d;
        end
    end

    // Frame RAM is deliberately not reset; blank hides its contents until the first swap.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[{~front_sel_q, bus.wr_addr}] <= bus.wr_rgb;
    end

    assign bus.wr_ready       = ~commit_pending_q;
    assign bus.commit_pending = commit_pending_q;
    assign bus.frame_start    = frame_start_q;
    assign bus.frame_count    = frame_count_q;
    assign bus.drv_red        = drv_rgb_q[23:16];
    assign bus.drv_green      = drv_rgb_q[15:8];
    assign bus.drv_blue       = drv_rgb_q[7:0];
endmodule

// File: tb/tb_ws2812b_frame_scheduler.sv
// Directed bench for ws2812b_frame_scheduler: bank swap, scaling, commit timing, reset.
module tb_ws2812b_frame_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    ws2812b_frame_scheduler_if #(.NUM_LEDS(4), .FCNT_W(16)) bus_if ();

    ws2812b_frame_scheduler #(.NUM_LEDS(4), .FCNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic pull(input logic [1:0] a, input logic commit);
        bus_if.drv_data_request = 1'b1;
        bus_if.drv_address      = a;
        bus_if.frame_commit     = commit;
        @(posedge clk); #1;
        bus_if.drv_data_request = 1'b0;
        bus_if.frame_commit     = 1'b0;
    endtask

    task automatic write_px(input logic [1:0] a, input logic [23:0] rgb);
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr  = a;
        bus_if.wr_rgb   = rgb;
        @(posedge clk); #1;
        bus_if.wr_valid = 1'b0;
    endtask

    task automatic commit_frame();
        bus_if.frame_commit = 1'b1;
        @(posedge clk); #1;
        bus_if.frame_commit = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] got;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        got = {bus_if.drv_red, bus_if.drv_green, bus_if.drv_blue};
        n_checks++;
        if (bus_if.wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_wr_ready got=%b exp=1", bus_if.wr_ready);
        end
        n_checks++;
        if (bus_if.commit_pending !== 1'b0) begin
            n_fail++; $display("FAIL reset_commit_pending got=%b exp=0", bus_if.commit_pending);
        end
        n_checks++;
        if (got !== 24'd0) begin
            n_fail++; $display("FAIL reset_drv got=%h exp=000000", got);
        end
        n_checks++;
        if (bus_if.frame_start !== 1'b0 || bus_if.frame_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_frame got start=%b count=%0d exp 0/0",
                               bus_if.frame_start, bus_if.frame_count);
        end
        reset = 1'b0;
        // Two frames pulled with no commit: blanked output throughout.
        for (int f = 0; f < 2; f++) begin
            for (int a = 0; a < 4; a++) begin
                pull(2'(a), 1'b0);
                got = {bus_if.drv_red, bus_if.drv_green, bus_if.drv_blue};
                n_checks++;
                if (got !== 24'd0) begin
                    n_fail++; $display("FAIL blank_frame%0d_addr%0d got=%h exp=000000", f, a, got);
                end
            end
        end
        n_checks++;
        if (bus_if.frame_count !== 16'd0) begin
            n_fail++; $display("FAIL blank_frame_count got=%0d exp=0", bus_if.frame_count);
        end
    endtask

    task automatic test_write_commit();
        logic [23:0] exp_px [4];
        logic [23:0] got;
        exp_px = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        for (int a = 0; a < 4; a++) write_px(2'(a), exp_px[a]);
        commit_frame();
        n_checks++;
        if (bus_if.commit_pending !== 1'b1 || bus_if.wr_ready !== 1'b0) begin
            n_fail++; $display("FAIL commit_pending_set got pend=%b rdy=%b exp 1/0",
                               bus_if.commit_pending, bus_if.wr_ready);
        end
        for (int a = 0; a < 4; a++) begin
            pull(2'(a), 1'b0);
            got = {bus_if.drv_red, bus_if.drv_green, bus_if.drv_blue};
            n_checks++;
            if (got !== exp_px[a]) begin
                n_fail++; $display("FAIL swap_pixel%0d got=%h exp=%h", a, got, exp_px[a]);
            end
            n_checks++;
            if (bus_if.frame_start !== (a == 0)) begin
                n_fail++; $display("FAIL frame_start_addr%0d got=%b exp=%b", a, bus_if.frame_start, a == 0);
            end
            if (a == 0) begin
                n_checks++;
                if (bus_if.frame_count !== 16'd1 || bus_if.commit_pending !== 1'b0) begin
                    n_fail++; $display("FAIL swap_state got count=%0d pend=%b exp 1/0",
                                       bus_if.frame_count, bus_if.commit_pending);
                end
            end
        end
    endtask

    task automatic test_brightness();
        logic [23:0] got;
        write_px(2'd0, 24'hC8640A);
        write_px(2'd1, 24'hC8C8C8);
        write_px(2'd2, 24'h808080);
        write_px(2'd3, 24'h102030);
        commit_frame();
        bus_if.brightness = 8'd127;
        pull(2'd0, 1'b0);
        got = {bus_if.drv_red, bus_if.drv_green, bus_if.drv_blue};
        n_checks++;
        if (got !== 24'h643205) begin
            n_fail++; $display("FAIL scale127_addr0 got=%h exp=643205", got);
        end
        bus_if.brightness = 8'd255;
        pull(2'd1, 1'b0);
        got = {bus_if.drv_red, bus_if.drv_green, bus_if.drv_blue};
        n_checks++;
        if (got !== 24'h646464) begin
            n_fail++; $display("FAIL midframe_bright got=%h exp=646464", got);
        end
        pull(2'd0, 1'b0);
        got = {bus_if.drv_red, bus_if.drv_green, bus_if.drv_blue};
        n_checks++;
        if (got !== 24'hC8640A || bus_if.frame_count !== 16'd2) begin
            n_fail++; $display("FAIL bright_next_frame got=%h count=%0d exp=c8640a/2", got, bus_if.frame_count);
        end
    endtask

    task automatic test_commit_at_boundary();
        logic [23:0] got;
        write_px(2'd0, 24'h010203);
        pull(2'd0, 1'b1);
        got = {bus_if.drv_red, bus_if.drv_green, bus_if.drv_blue};
        n_checks++;
        if (got !== 24'hC8640A || bus_if.frame_count !== 16'd2 || bus_if.commit_pending !== 1'b1) begin
            n_fail++; $display("FAIL boundary_commit_noswap got=%h count=%0d pend=%b exp=c8640a/2/1",
                               got, bus_if.frame_count, bus_if.commit_pending);
        end
        pull(2'd0, 1'b0);
        got = {bus_if.drv_red, bus_if.drv_green, bus_if.drv_blue};
        n_checks++;
        if (got !== 24'h010203 || bus_if.frame_count !== 16'd3) begin
            n_fail++; $display("FAIL boundary_commit_later got=%h count=%0d exp=010203/3", got, bus_if.frame_count);
        end
    endtask

    task automatic test_write_blocked();
        logic [23:0] got;
        write_px(2'd2, 24'h0A0B0C);
        commit_frame();
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr  = 2'd2;
        bus_if.wr_rgb   = 24'hFFFFFF;
        #1;
        n_checks++;
        if (bus_if.wr_ready !== 1'b0) begin
            n_fail++; $display("FAIL blocked_wr_ready got=%b exp=0", bus_if.wr_ready);
        end
        @(posedge clk); #1;
        bus_if.wr_valid = 1'b0;
        pull(2'd2, 1'b0);
        got = {bus_if.drv_red, bus_if.drv_green, bus_if.drv_blue};
        n_checks++;
        if (got !== 24'h778899) begin
            n_fail++; $display("FAIL displayed_unchanged got=%h exp=778899", got);
        end
        pull(2'd0, 1'b0);
        pull(2'd2, 1'b0);
        got = {bus_if.drv_red, bus_if.drv_green, bus_if.drv_blue};
        n_checks++;
        if (got !== 24'h0A0B0C || bus_if.frame_count !== 16'd4) begin
            n_fail++; $display("FAIL blocked_write_ignored got=%h count=%0d exp=0a0b0c/4", got, bus_if.frame_count);
        end
        n_checks++;
        if (bus_if.wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_ready_after_swap got=%b exp=1", bus_if.wr_ready);
        end
        write_px(2'd1, 24'h123456);
        commit_frame();
        pull(2'd0, 1'b0);
        pull(2'd1, 1'b0);
        got = {bus_if.drv_red, bus_if.drv_green, bus_if.drv_blue};
        n_checks++;
        if (got !== 24'h123456 || bus_if.frame_count !== 16'd5) begin
            n_fail++; $display("FAIL write_after_swap got=%h count=%0d exp=123456/5", got, bus_if.frame_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] got;
        write_px(2'd3, 24'h445566);
        commit_frame();
        pull(2'd0, 1'b0);
        bus_if.drv_data_request = 1'b1;
        bus_if.drv_address      = 2'd0;
        reset = 1'b1;
        @(posedge clk); #1;
        bus_if.drv_data_request = 1'b0;
        reset = 1'b0;
        got = {bus_if.drv_red, bus_if.drv_green, bus_if.drv_blue};
        n_checks++;
        if (got !== 24'd0 || bus_if.frame_start !== 1'b0 || bus_if.frame_count !== 16'd0 ||
            bus_if.commit_pending !== 1'b0 || bus_if.wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_state got drv=%h start=%b count=%0d pend=%b rdy=%b exp 0/0/0/0/1",
                               got, bus_if.frame_start, bus_if.frame_count,
                               bus_if.commit_pending, bus_if.wr_ready);
        end
        for (int a = 0; a < 4; a++) begin
            pull(2'(a), 1'b0);
            got = {bus_if.drv_red, bus_if.drv_green, bus_if.drv_blue};
            n_checks++;
            if (got !== 24'd0) begin
                n_fail++; $display("FAIL midreset_blank_addr%0d got=%h exp=000000", a, got);
            end
        end
        commit_frame();
        pull(2'd0, 1'b0);
        got = {bus_if.drv_red, bus_if.drv_green, bus_if.drv_blue};
        n_checks++;
        if (got !== 24'h010203 || bus_if.frame_count !== 16'd1) begin
            n_fail++; $display("FAIL midreset_first_swap got=%h count=%0d exp=010203/1", got, bus_if.frame_count);
        end
        pull(2'd1, 1'b0);
        got = {bus_if.drv_red, bus_if.drv_green, bus_if.drv_blue};
        n_checks++;
        if (got !== 24'h123456) begin
            n_fail++; $display("FAIL midreset_addr1 got=%h exp=123456", got);
        end
    endtask

    initial begin
        bus_if.wr_valid         = 1'b0;
        bus_if.wr_addr          = 2'd0;
        bus_if.wr_rgb           = 24'd0;
        bus_if.frame_commit     = 1'b0;
        bus_if.brightness       = 8'd255;
        bus_if.drv_data_request = 1'b0;
        bus_if.drv_address      = 2'd0;
        test_reset();
        test_write_commit();
        test_brightness();
        test_commit_at_boundary();
        test_write_blocked();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
